lcd_timing_gen: RTL and testbench

- Pixel-timing stage directly downstream of the LCD power-up sequencer.
- Consumes its en_sync, pixel_en and de_en enables. Generates HSYNC/VSYNC/DE and pixel coordinates for the 480x272 TFT panel.
- Drives a 1-cycle-latency pixel request to the frame-buffer reader, so returned RGB data lines up with DE.
- All logic runs on clk_out, the pixel clock.

---
 rtl/lcd_timing_gen_pkg.sv | 25 ++
 rtl/lcd_timing_gen_if.sv | 30 +++
 rtl/lcd_timing_gen_axis_counter.sv | 52 +++++
 rtl/lcd_timing_gen.sv | 129 ++++++++++++
 tb/tb_lcd_timing_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_gen_pkg.sv
// Shared constants and state encoding for the 480x272 TFT pixel-timing generator.
// The default timing values describe the panel; other blocks override them through parameters.
package lcd_timing_pkg;

    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FP     = 2;
    localparam int LCD_H_PULSE  = 41;
    localparam int LCD_H_BP     = 2;

    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FP     = 2;
    localparam int LCD_V_PULSE  = 10;
    localparam int LCD_V_BP     = 2;

    localparam int LCD_H_TOTAL  = LCD_H_PULSE + LCD_H_BP + LCD_H_ACTIVE + LCD_H_FP;
    localparam int LCD_V_TOTAL  = LCD_V_PULSE + LCD_V_BP + LCD_V_ACTIVE + LCD_V_FP;

    localparam int LCD_CNT_W    = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lcd_state_e;

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Sequencer enables in, panel timing out.
// The timing generator drives through the master modport; the panel or frame-buffer side uses slave.
interface lcd_timing_gen_if
    import lcd_timing_pkg::*;
#(
    parameter int CNT_W = LCD_CNT_W
);
    logic             en_sync;
    logic             pixel_en;
    logic             de_en;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             pix_req;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             frame_start;
    logic [7:0]       frame_cnt;

    modport master (
        input  en_sync, pixel_en, de_en,
        output hsync, vsync, de, pix_req, pix_x, pix_y, frame_start, frame_cnt
    );

    modport slave (
        output en_sync, pixel_en, de_en,
        input  hsync, vsync, de, pix_req, pix_x, pix_y, frame_start, frame_cnt
    );

endinterface

// File: rtl/lcd_timing_gen_axis_counter.sv
// One timing axis: a wrapping position counter plus region decodes (sync, active, active-next).
// Used once per line (horizontal) and once per frame (vertical).
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int TOTAL  = LCD_H_TOTAL,
    parameter int PULSE  = LCD_H_PULSE,
    parameter int BP     = LCD_H_BP,
    parameter int ACTIVE = LCD_H_ACTIVE,
    parameter int CNT_W  = LCD_CNT_W
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_active,
    output logic             next_active
);
    localparam int A0 = PULSE + BP;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign wrap = inc && (cnt_q == CNT_W'(TOTAL - 1));

    // Integer compares keep the decodes correct even when TOTAL reaches 2^CNT_W.
    assign in_sync     = int'(cnt_q) < PULSE;
    assign in_active   = (int'(cnt_q) >= A0) && (int'(cnt_q) < A0 + ACTIVE);
    assign next_active = (int'(cnt_q) + 1 >= A0) && (int'(cnt_q) + 1 < A0 + ACTIVE);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Pixel-timing stage: HSYNC/VSYNC/DE, pixel coordinates and a one-cycle-early fetch request.
// Every output is a registered decode of the counters, so it trails its counter value by one clock.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int H_PULSE  = LCD_H_PULSE,
    parameter int H_BP     = LCD_H_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int V_PULSE  = LCD_V_PULSE,
    parameter int V_BP     = LCD_V_BP,
    parameter int CNT_W    = LCD_CNT_W
) (
    input  logic             clk_out,
    input  logic             rst,
    lcd_timing_gen_if.master tim
);
    localparam int H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;
    localparam int HA0     = H_PULSE + H_BP;
    localparam int VA0     = V_PULSE + V_BP;

    lcd_state_e       state_q, state_d;
    logic             run;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    logic             h_in_sync, v_in_sync;
    logic             h_in_active, v_in_active;
    logic             h_next_active, v_next_active_unused;

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             pix_req_q, pix_req_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic [CNT_W-1:0] pix_y_q, pix_y_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    // Counting only happens while already in RUN with the enable still high; otherwise counters clear.
    assign run = (state_q == RUN) && tim.en_sync;

    lcd_axis_counter #(
        .TOTAL(H_TOTAL), .PULSE(H_PULSE), .BP(H_BP), .ACTIVE(H_ACTIVE), .CNT_W(CNT_W)
    ) u_hcnt (
        .clk_out(clk_out), .rst(rst), .inc(run), .clr(!run),
        .cnt(h_cnt), .wrap(h_wrap), .in_sync(h_in_sync),
        .in_active(h_in_active), .next_active(h_next_active)
    );

    lcd_axis_counter #(
        .TOTAL(V_TOTAL), .PULSE(V_PULSE), .BP(V_BP), .ACTIVE(V_ACTIVE), .CNT_W(CNT_W)
    ) u_vcnt (
        .clk_out(clk_out), .rst(rst), .inc(h_wrap), .clr(!run),
        .cnt(v_cnt), .wrap(v_wrap), .in_sync(v_in_sync),
        .in_active(v_in_active), .next_active(v_next_active_unused)
    );

    always_ff @(posedge clk_out) begin
        if (rst) begin
            state_q       <= IDLE;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            pix_req_q     <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pix_req_q     <= pix_req_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tim.en_sync)  state_d = RUN;
            RUN:     if (!tim.en_sync) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outside a running cycle everything falls back to reset values; frame_cnt alone survives a stop.
    always_comb begin
        hsync_d       = 1'b1;
        vsync_d       = 1'b1;
        de_d          = 1'b0;
        pix_req_d     = 1'b0;
        pix_x_d       = '0;
        pix_y_d       = '0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (run) begin
            hsync_d       = ~h_in_sync;
            vsync_d       = ~v_in_sync;
            de_d          = h_in_active & v_in_active & tim.de_en;
            pix_req_d     = h_next_active & v_in_active & tim.pixel_en;
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            if (de_d) begin
                pix_x_d = h_cnt - CNT_W'(HA0);
                pix_y_d = v_cnt - CNT_W'(VA0);
            end
            if (v_wrap) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    assign tim.hsync       = hsync_q;
    assign tim.vsync       = vsync_q;
    assign tim.de          = de_q;
    assign tim.pix_req     = pix_req_q;
    assign tim.pix_x       = pix_x_q;
    assign tim.pix_y       = pix_y_q;
    assign tim.frame_start = frame_start_q;
    assign tim.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a shrunken 15x8 raster so that 256 whole frames stay short.
// Line: sync 3, back porch 2, active 8, front porch 2. Frame: sync 2, back porch 1, active 4, front porch 1.
module tb_lcd_timing_gen;
    localparam int CNT_W    = 10;
    localparam int H_PULSE  = 3;
    localparam int H_BP     = 2;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int V_PULSE  = 2;
    localparam int V_BP     = 1;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int FRAME    = 120;

    logic clk_out = 1'b0;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    int hsLow, vsLow, hsFalls, deHigh, reqHigh, fsCount, maxRun;
    int firstDe, firstReq, firstX, firstY, lastX, lastY;

    lcd_timing_gen_if #(.CNT_W(CNT_W)) tim ();

    lcd_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_PULSE(H_PULSE), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_PULSE(V_PULSE), .V_BP(V_BP),
        .CNT_W(CNT_W)
    ) dut (
        .clk_out(clk_out),
        .rst(rst),
        .tim(tim)
    );

    always #5 clk_out = ~clk_out;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_out);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag, input int expFrameCnt);
        checkOutput({tag, "_hsync"}, 32'(tim.hsync), 1);
        checkOutput({tag, "_vsync"}, 32'(tim.vsync), 1);
        checkOutput({tag, "_de"}, 32'(tim.de), 0);
        checkOutput({tag, "_pix_req"}, 32'(tim.pix_req), 0);
        checkOutput({tag, "_pix_x"}, 32'(tim.pix_x), 0);
        checkOutput({tag, "_pix_y"}, 32'(tim.pix_y), 0);
        checkOutput({tag, "_frame_start"}, 32'(tim.frame_start), 0);
        checkOutput({tag, "_frame_cnt"}, 32'(tim.frame_cnt), 32'(expFrameCnt));
    endtask

    // Samples one whole frame starting at frame position 0; enables are toggled at the given indices.
    task automatic applyStimulus(input int deOff, input int deOn, input int pixOff, input int pixOn);
        int   runLen = 0;
        logic prevHs = 1'b1;
        hsLow = 0; vsLow = 0; hsFalls = 0; deHigh = 0; reqHigh = 0; fsCount = 0; maxRun = 0;
        firstDe = -1; firstReq = -1; firstX = -1; firstY = -1; lastX = -1; lastY = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (!tim.hsync) hsLow++;
            if (!tim.hsync && prevHs) hsFalls++;
            prevHs = tim.hsync;
            if (!tim.vsync) vsLow++;
            if (tim.frame_start) fsCount++;
            if (tim.pix_req) begin
                reqHigh++;
                if (firstReq < 0) firstReq = i;
            end
            if (tim.de) begin
                deHigh++;
                runLen++;
                if (runLen > maxRun) maxRun = runLen;
                if (firstDe < 0) begin
                    firstDe = i;
                    firstX  = int'(tim.pix_x);
                    firstY  = int'(tim.pix_y);
                end
                lastX = int'(tim.pix_x);
                lastY = int'(tim.pix_y);
            end else begin
                runLen = 0;
            end
            if (i == deOff)  tim.de_en    = 1'b0;
            if (i == deOn)   tim.de_en    = 1'b1;
            if (i == pixOff) tim.pixel_en = 1'b0;
            if (i == pixOn)  tim.pixel_en = 1'b1;
            tick(1);
        end
    endtask

    initial begin
        $display("[TB] lcd_timing_gen directed test start");
        rst          = 1'b1;
        tim.en_sync  = 1'b0;
        tim.de_en    = 1'b1;
        tim.pixel_en = 1'b1;
        tick(3);
        checkIdle("reset", 0);
        rst = 1'b0;
        tick(2);
        checkIdle("idle", 0);

        // The enabling edge only moves IDLE to RUN; the next edge decodes position 0.
        tim.en_sync = 1'b1;
        tick(1);
        checkOutput("start_edge_hsync", 32'(tim.hsync), 1);
        tick(1);
        checkOutput("first_run_hsync", 32'(tim.hsync), 0);
        checkOutput("first_run_vsync", 32'(tim.vsync), 0);
        checkOutput("first_run_frame_start", 32'(tim.frame_start), 1);

        applyStimulus(-1, -1, -1, -1);
        checkOutput("f1_hsync_low", hsLow, 24);
        checkOutput("f1_hsync_falls", hsFalls, 8);
        checkOutput("f1_vsync_low", vsLow, 30);
        checkOutput("f1_de_cycles", deHigh, 32);
        checkOutput("f1_de_run", maxRun, 8);
        checkOutput("f1_req_cycles", reqHigh, 32);
        checkOutput("f1_frame_starts", fsCount, 1);
        checkOutput("f1_first_de", firstDe, 50);
        checkOutput("f1_first_req", firstReq, 49);
        checkOutput("f1_first_x", firstX, 0);
        checkOutput("f1_first_y", firstY, 0);
        checkOutput("f1_last_x", lastX, 7);
        checkOutput("f1_last_y", lastY, 3);
        checkOutput("f1_frame_cnt", 32'(tim.frame_cnt), 1);
        checkOutput("f2_frame_start", 32'(tim.frame_start), 1);

        // de_en low across line 3, pixel_en low across line 4.
        applyStimulus(44, 59, 59, 74);
        checkOutput("f2_hsync_low", hsLow, 24);
        checkOutput("f2_hsync_falls", hsFalls, 8);
        checkOutput("f2_vsync_low", vsLow, 30);
        checkOutput("f2_de_cycles", deHigh, 24);
        checkOutput("f2_first_de", firstDe, 65);
        checkOutput("f2_req_cycles", reqHigh, 24);
        checkOutput("f2_first_req", firstReq, 49);
        checkOutput("f2_frame_starts", fsCount, 1);
        checkOutput("f2_frame_cnt", 32'(tim.frame_cnt), 2);

        // Drop en_sync while inside the active window of line 3.
        tick(52);
        checkOutput("pre_stop_de", 32'(tim.de), 1);
        checkOutput("pre_stop_pix_x", 32'(tim.pix_x), 2);
        checkOutput("pre_stop_pix_y", 32'(tim.pix_y), 0);
        tim.en_sync = 1'b0;
        tick(1);
        checkIdle("stop", 2);
        checkOutput("stop_h_cnt", 32'(dut.h_cnt), 0);
        checkOutput("stop_v_cnt", 32'(dut.v_cnt), 0);
        tim.en_sync = 1'b1;
        tick(2);
        checkOutput("restart_hsync", 32'(tim.hsync), 0);
        checkOutput("restart_vsync", 32'(tim.vsync), 0);
        checkOutput("restart_frame_start", 32'(tim.frame_start), 1);
        checkOutput("restart_frame_cnt", 32'(tim.frame_cnt), 2);
        applyStimulus(-1, -1, -1, -1);
        checkOutput("f3_de_cycles", deHigh, 32);
        checkOutput("f3_first_de", firstDe, 50);
        checkOutput("f3_frame_cnt", 32'(tim.frame_cnt), 3);

        // Reset in the middle of an active line.
        tick(52);
        checkOutput("pre_rst_de", 32'(tim.de), 1);
        rst = 1'b1;
        tick(1);
        checkIdle("midrst", 0);
        rst = 1'b0;
        tick(2);
        checkOutput("post_rst_frame_start", 32'(tim.frame_start), 1);
        tick(FRAME * 255);
        checkOutput("frame_cnt_255", 32'(tim.frame_cnt), 255);
        tick(FRAME);
        checkOutput("frame_cnt_wrap", 32'(tim.frame_cnt), 0);
        checkOutput("wrap_frame_start", 32'(tim.frame_start), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
